// File: rtl/i2s_pkg.sv
// Shared definitions for the LED-panel serial link (streamer and i2s_mask receivers).
// Header layout: {num_modules_x, num_modules_y, 2'b00, row_num}, MSB first.
package i2s_pkg;

   localparam int unsigned WORD_BITS   = 16;
   localparam int unsigned MAX_MODULES = 16;
   localparam int unsigned MAX_WORDS   = MAX_MODULES * MAX_MODULES;
   localparam int unsigned WORD_CNT_W  = $clog2(MAX_WORDS + 1);
   localparam int unsigned BIT_CNT_W   = $clog2(WORD_BITS);

   localparam int unsigned HDR_X_MSB   = 15;
   localparam int unsigned HDR_X_LSB   = 12;
   localparam int unsigned HDR_Y_MSB   = 11;
   localparam int unsigned HDR_Y_LSB   = 8;
   localparam int unsigned HDR_RSV_MSB = 7;
   localparam int unsigned HDR_RSV_LSB = 6;
   localparam int unsigned HDR_ROW_MSB = 5;
   localparam int unsigned HDR_ROW_LSB = 0;
   localparam int unsigned ROW_W       = HDR_ROW_MSB - HDR_ROW_LSB + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2,
      ST_GAP    = 2'd3
   } i2s_state_t;

   function automatic logic [WORD_BITS-1:0] make_header(
      input logic [3:0]       x,
      input logic [3:0]       y,
      input logic [ROW_W-1:0] row
   );
      logic [WORD_BITS-1:0] h;
      h = '0;
      h[HDR_X_MSB:HDR_X_LSB]     = x;
      h[HDR_Y_MSB:HDR_Y_LSB]     = y;
      h[HDR_RSV_MSB:HDR_RSV_LSB] = '0;
      h[HDR_ROW_MSB:HDR_ROW_LSB] = row;
      return h;
   endfunction

   function automatic logic [WORD_CNT_W-1:0] word_count(
      input logic [3:0] x,
      input logic [3:0] y
   );
      return (WORD_CNT_W'(x) + WORD_CNT_W'(1)) * (WORD_CNT_W'(y) + WORD_CNT_W'(1));
   endfunction

endpackage

// File: rtl/i2s_word_shifter.sv
// 16-bit MSB-first load/shift register; dout is the flop driving i2s_data.
// word_end is high while bit 0 of the current word is on the line.
module i2s_word_shifter
   import i2s_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [WORD_BITS-1:0] load_word,
   input  logic                 shift,
   output logic                 dout,
   output logic                 word_end
);

   logic [WORD_BITS-1:0] sr;
   logic [BIT_CNT_W-1:0] bit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         sr      <= load_word;
         bit_cnt <= '0;
      end else if (shift) begin
         sr      <= {sr[WORD_BITS-2:0], 1'b0};
         bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
   end

   assign dout     = sr[WORD_BITS-1];
   assign word_end = (bit_cnt == BIT_CNT_W'(WORD_BITS - 1));

endmodule

// File: rtl/i2s_row_streamer.sv
// Serialises one display row (header + pixel words) onto i2s_data/i2s_clk_en.
// A one-word holding register prefetches pixels; an empty holder at a word boundary stalls the clock.
module i2s_row_streamer
   import i2s_pkg::*;
#(
   parameter int unsigned NUM_ROWS   = 8,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [3:0]           num_modules_x,
   input  logic [3:0]           num_modules_y,
   input  logic [WORD_BITS-1:0] pix_data,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic                 i2s_data,
   output logic                 i2s_clk_en,
   output logic                 busy,
   output logic                 row_done,
   output logic                 frame_done,
   output logic [ROW_W-1:0]     row_num,
   output logic                 underrun
);

   i2s_state_t            state;
   logic [WORD_CNT_W-1:0] word_cnt;
   logic [WORD_CNT_W-1:0] fetch_cnt;
   logic [WORD_BITS-1:0]  hold_data;
   logic                  hold_valid;
   logic [3:0]            gap_cnt;

   logic                  streaming;
   logic                  stalled;
   logic                  boundary;
   logic                  accept;
   logic                  sh_load;
   logic                  sh_shift;
   logic [WORD_BITS-1:0]  sh_word;
   logic                  sh_word_end;
   logic                  take_hold;
   logic                  take_pix;
   logic                  stall_now;
   logic                  end_row;

   assign busy      = (state != ST_IDLE);
   assign pix_ready = (state == ST_HEADER || state == ST_DATA) && !hold_valid && (fetch_cnt != '0);
   assign accept    = pix_valid && pix_ready;
   assign streaming = (state == ST_HEADER || state == ST_DATA) && i2s_clk_en;
   assign stalled   = (state == ST_DATA) && !i2s_clk_en;
   assign boundary  = streaming && sh_word_end;

   // A word accepted while the shifter is waiting for it bypasses the holder,
   // so its bit 15 goes out the very next cycle.
   always_comb begin
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      sh_word   = hold_data;
      take_hold = 1'b0;
      take_pix  = 1'b0;
      stall_now = 1'b0;
      end_row   = 1'b0;
      if (state == ST_IDLE && start) begin
         sh_load = 1'b1;
         sh_word = make_header(num_modules_x, num_modules_y, row_num);
      end else if (boundary) begin
         if (word_cnt == '0) begin
            sh_load = 1'b1;
            sh_word = '0;
            end_row = 1'b1;
         end else if (hold_valid) begin
            sh_load   = 1'b1;
            take_hold = 1'b1;
         end else if (accept) begin
            sh_load  = 1'b1;
            sh_word  = pix_data;
            take_pix = 1'b1;
         end else begin
            stall_now = 1'b1;
         end
      end else if (stalled && accept) begin
         sh_load  = 1'b1;
         sh_word  = pix_data;
         take_pix = 1'b1;
      end else if (streaming) begin
         sh_shift = 1'b1;
      end
   end

   i2s_word_shifter u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .load_word (sh_word),
      .shift     (sh_shift),
      .dout      (i2s_data),
      .word_end  (sh_word_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         word_cnt   <= '0;
         fetch_cnt  <= '0;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         gap_cnt    <= '0;
         i2s_clk_en <= 1'b0;
         row_done   <= 1'b0;
         frame_done <= 1'b0;
         row_num    <= '0;
         underrun   <= 1'b0;
      end else begin
         row_done   <= 1'b0;
         frame_done <= 1'b0;

         if (accept)
            fetch_cnt <= fetch_cnt - WORD_CNT_W'(1);
         if (accept && !take_pix) begin
            hold_valid <= 1'b1;
            hold_data  <= pix_data;
         end else if (take_hold) begin
            hold_valid <= 1'b0;
         end
         if (take_hold || take_pix)
            word_cnt <= word_cnt - WORD_CNT_W'(1);

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_HEADER;
                  i2s_clk_en <= 1'b1;
                  word_cnt   <= word_count(num_modules_x, num_modules_y);
                  fetch_cnt  <= word_count(num_modules_x, num_modules_y);
                  underrun   <= 1'b0;
               end
            end
            ST_HEADER: begin
               if (boundary) begin
                  state <= ST_DATA;
                  if (stall_now) begin
                     i2s_clk_en <= 1'b0;
                     underrun   <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (end_row) begin
                  state      <= ST_GAP;
                  i2s_clk_en <= 1'b0;
                  gap_cnt    <= 4'(GAP_CYCLES - 1);
               end else if (stall_now) begin
                  i2s_clk_en <= 1'b0;
                  underrun   <= 1'b1;
               end else if (take_pix) begin
                  i2s_clk_en <= 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  state    <= ST_IDLE;
                  row_done <= 1'b1;
                  if (row_num == ROW_W'(NUM_ROWS - 1)) begin
                     row_num    <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     row_num <= row_num + ROW_W'(1);
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_row_streamer.sv
// Directed row vectors with hand-computed headers, lengths and stall positions,
// plus hand-written reset sequences around them.
module tb_i2s_row_streamer;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  num_modules_x;
   logic [3:0]  num_modules_y;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        i2s_data;
   logic        i2s_clk_en;
   logic        busy;
   logic        row_done;
   logic        frame_done;
   logic [5:0]  row_num;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   bit cap   [0:4199];
   bit en_h  [0:4599];
   bit dat_h [0:4599];
   bit busy_h[0:4599];

   typedef struct {
      logic [3:0]  x;
      logic [3:0]  y;
      int          drop_word;
      int          drop_len;
      int          restart_at;
      bit          idle_after;
      logic [15:0] exp_hdr;
      int          exp_words;
      int          exp_en;
      int          exp_stall;
      int          exp_first_stall;
      logic [5:0]  exp_row;
      logic        exp_frame;
      logic        exp_under;
   } vec_t;

   vec_t vecs[10];

   i2s_row_streamer #(.NUM_ROWS(8), .GAP_CYCLES(GAP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .num_modules_x (num_modules_x),
      .num_modules_y (num_modules_y),
      .pix_data      (pix_data),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .i2s_data      (i2s_data),
      .i2s_clk_en    (i2s_clk_en),
      .busy          (busy),
      .row_done      (row_done),
      .frame_done    (frame_done),
      .row_num       (row_num),
      .underrun      (underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pix_word(input int r, input int k);
      logic [31:0] t;
      t = 32'(k) * 32'd40503 + 32'(r) * 32'd7919 + 32'h5A3C;
      return t[15:0] ^ t[31:16];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_row(input int vi);
      vec_t v;
      int idx, withheld, rd_off, ready_after, ncap, stray_fd, last_off;
      int first_en, last_en, stall, first_stall, frozen_bad, gap_bad, busy_low, bad, pos;
      bit done;
      logic [15:0] w;
      v = vecs[vi];
      start = 1'b1;
      num_modules_x = v.x;
      num_modules_y = v.y;
      pix_valid = 1'b0;
      pix_data = '0;
      idx = 0; withheld = 0; rd_off = 0; ready_after = 0; ncap = 0; stray_fd = 0;
      done = 1'b0; last_off = 0;
      for (int c = 1; c <= v.exp_en + 300 && !done; c++) begin
         @(negedge clk);
         last_off = c;
         en_h[c] = i2s_clk_en; dat_h[c] = i2s_data; busy_h[c] = busy;
         if (i2s_clk_en && ncap < 4200) begin
            cap[ncap] = i2s_data;
            ncap++;
         end
         if (frame_done && !row_done) stray_fd++;
         if (row_done) begin
            done = 1'b1;
            rd_off = c;
            check($sformatf("r%0d_row_num", vi), 32'(row_num), 32'(v.exp_row));
            check($sformatf("r%0d_frame_done", vi), 32'(frame_done), 32'(v.exp_frame));
            check($sformatf("r%0d_underrun", vi), 32'(underrun), 32'(v.exp_under));
            check($sformatf("r%0d_busy_at_done", vi), 32'(busy), 32'd0);
         end
         start = (c == v.restart_at);
         num_modules_x = ~v.x;
         num_modules_y = v.y ^ 4'h5;
         if (idx < v.exp_words) begin
            if (idx == v.drop_word && withheld < v.drop_len && pix_ready) begin
               pix_valid = 1'b0;
               withheld++;
            end else begin
               pix_valid = 1'b1;
               pix_data = pix_word(vi, idx);
            end
         end else begin
            pix_valid = 1'b1;
            pix_data = 16'hDEAD;
            if (pix_ready) ready_after++;
         end
         if (pix_valid && pix_ready) idx++;
      end
      check($sformatf("r%0d_row_done_seen", vi), 32'(done), 32'd1);
      if (!done) rd_off = last_off;

      w = '0;
      for (int b = 0; b < 16; b++) w = {w[14:0], (b < ncap) ? cap[b] : 1'b0};
      check($sformatf("r%0d_header", vi), 32'(w), 32'(v.exp_hdr));
      bad = 0;
      for (int k = 0; k < v.exp_words; k++) begin
         w = '0;
         for (int b = 0; b < 16; b++) begin
            pos = 16 + 16 * k + b;
            w = {w[14:0], (pos < ncap) ? cap[pos] : 1'b0};
         end
         if (w !== pix_word(vi, k)) bad++;
      end
      check($sformatf("r%0d_bad_words", vi), 32'(bad), 32'd0);
      check($sformatf("r%0d_en_cycles", vi), 32'(ncap), 32'(v.exp_en));

      first_en = 0; last_en = 0;
      for (int o = 1; o <= rd_off; o++)
         if (en_h[o]) begin
            if (first_en == 0) first_en = o;
            last_en = o;
         end
      check($sformatf("r%0d_first_en", vi), 32'(first_en), 32'd1);
      stall = last_en - first_en + 1 - ncap;
      check($sformatf("r%0d_stall_len", vi), 32'(stall), 32'(v.exp_stall));
      first_stall = 0; frozen_bad = 0;
      for (int o = first_en; o <= last_en && o > 0; o++)
         if (!en_h[o]) begin
            if (first_stall == 0) first_stall = o;
            if (dat_h[o] != dat_h[o-1]) frozen_bad++;
         end
      check($sformatf("r%0d_first_stall", vi), 32'(first_stall), 32'(v.exp_first_stall));
      check($sformatf("r%0d_stall_data_moved", vi), 32'(frozen_bad), 32'd0);
      check($sformatf("r%0d_gap_len", vi), 32'(rd_off - last_en), 32'(GAP + 1));
      gap_bad = 0;
      for (int o = last_en + 1; o <= rd_off; o++)
         if (en_h[o] || dat_h[o]) gap_bad++;
      check($sformatf("r%0d_gap_not_quiet", vi), 32'(gap_bad), 32'd0);
      busy_low = 0;
      for (int o = 1; o < rd_off; o++)
         if (!busy_h[o]) busy_low++;
      check($sformatf("r%0d_busy_low", vi), 32'(busy_low), 32'd0);
      check($sformatf("r%0d_words_accepted", vi), 32'(idx), 32'(v.exp_words));
      check($sformatf("r%0d_ready_after_last", vi), 32'(ready_after), 32'd0);
      check($sformatf("r%0d_stray_frame_done", vi), 32'(stray_fd), 32'd0);

      if (v.idle_after) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("r%0d_idle_after", vi), 32'({busy, row_done}), 32'd0);
         end
      end
   endtask

   initial begin
      //          x     y     dw  dl  rs  idle  hdr       N    en    st  fs  row  fd    ur
      vecs[0] = '{4'd3, 4'd3, -1, 0,  -1, 1'b0, 16'h3300, 16,  272,  0,  0,  6'd1, 1'b0, 1'b0};
      vecs[1] = '{4'd3, 4'd3,  3, 20, -1, 1'b0, 16'h3301, 16,  272,  5,  65, 6'd2, 1'b0, 1'b1};
      vecs[2] = '{4'd0, 4'd0, -1, 0,  -1, 1'b0, 16'h0002, 1,   32,   0,  0,  6'd3, 1'b0, 1'b0};
      vecs[3] = '{4'd1, 4'd2,  0, 18,  5, 1'b1, 16'h1203, 6,   112,  3,  17, 6'd4, 1'b0, 1'b1};
      vecs[4] = '{4'd15,4'd15,-1, 0,  -1, 1'b0, 16'hFF04, 256, 4112, 0,  0,  6'd5, 1'b0, 1'b0};
      vecs[5] = '{4'd2, 4'd0, -1, 0,  -1, 1'b0, 16'h2005, 3,   64,   0,  0,  6'd6, 1'b0, 1'b0};
      vecs[6] = '{4'd0, 4'd7, -1, 0,  -1, 1'b0, 16'h0706, 8,   144,  0,  0,  6'd7, 1'b0, 1'b0};
      vecs[7] = '{4'd4, 4'd1, -1, 0,  -1, 1'b0, 16'h4107, 10,  176,  0,  0,  6'd0, 1'b1, 1'b0};
      vecs[8] = '{4'd1, 4'd1, -1, 0,  -1, 1'b0, 16'h1100, 4,   80,   0,  0,  6'd1, 1'b0, 1'b0};
      vecs[9] = '{4'd3, 4'd3, -1, 0,  -1, 1'b0, 16'h3300, 16,  272,  0,  0,  6'd1, 1'b0, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      num_modules_x = '0;
      num_modules_y = '0;
      pix_data = '0;
      pix_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs",
            32'({pix_ready, i2s_data, i2s_clk_en, busy, row_done, frame_done, row_num, underrun}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i <= 8; i++) run_row(i);

      // Abandon a stalled, partially sent row with an asynchronous reset.
      begin
         int idx;
         idx = 0;
         start = 1'b1;
         num_modules_x = 4'd3;
         num_modules_y = 4'd3;
         pix_valid = 1'b0;
         for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            pix_valid = (c >= 20);
            pix_data = pix_word(99, idx);
            if (pix_valid && pix_ready) idx++;
         end
         check("midrow_busy", 32'(busy), 32'd1);
         check("midrow_underrun", 32'(underrun), 32'd1);
         check("midrow_row_num", 32'(row_num), 32'd1);
         #2 rst_n = 1'b0;
         #1;
         check("async_reset_outputs",
               32'({pix_ready, i2s_data, i2s_clk_en, busy, row_done, frame_done, row_num, underrun}), 32'd0);
         pix_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
      end

      run_row(9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
